// File: rtl/hnf_plru_sram_ctrl.sv
// hnf_plru_sram_ctrl
//   Tree-pseudo-LRU state store for the HN-F cache pipeline. Wraps one
//   single-port synchronous SRAM of 2^INDEX_WIDTH entries x (WAYS-1) bits.
//   After reset the whole array is swept to zero, one index per cycle.
//   It then serves pipelined lookups and read-modify-write PLRU updates.
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   rd_valid_i/index   lookup request; accepted when rd_ready_o is high
//   rd_ready_o         RUN, no write-back pending, no competing update
//   upd_valid_i/index/way  access update; accepted when upd_ready_o is high
//   upd_ready_o        RUN and no write-back pending
//   rd_data_valid_q    one-cycle pulse two cycles after a lookup is accepted
//   rd_data_q          raw tree state of the looked-up set (held between reads)
//   victim_way_q       PLRU victim decoded from rd_data_q (held between reads)
//   init_done_q        high once the initialisation sweep has finished
module hnf_plru_sram_ctrl #(
  parameter  int INDEX_WIDTH = 10,
  parameter  int WAYS        = 16,
  localparam int LRU_WIDTH   = WAYS - 1,
  localparam int WAY_WIDTH   = $clog2(WAYS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_valid_i,
  input  logic [INDEX_WIDTH-1:0] rd_index_i,
  output logic                   rd_ready_o,
  input  logic                   upd_valid_i,
  input  logic [INDEX_WIDTH-1:0] upd_index_i,
  input  logic [WAY_WIDTH-1:0]   upd_way_i,
  output logic                   upd_ready_o,
  output logic                   rd_data_valid_q,
  output logic [LRU_WIDTH-1:0]   rd_data_q,
  output logic [WAY_WIDTH-1:0]   victim_way_q,
  output logic                   init_done_q
);

  // Lookup latency: accept -> SRAM output -> output register.
  localparam int STAGES = 2;
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = '1;

  typedef enum logic {INIT, RUN} state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] init_cnt_q;

  logic                   wb_q;
  logic [INDEX_WIDTH-1:0] wb_index_q;
  logic [WAY_WIDTH-1:0]   wb_way_q;

  logic [LRU_WIDTH-1:0]   mem [2**INDEX_WIDTH];
  logic [LRU_WIDTH-1:0]   mem_rdata_q;
  logic                   mem_en, mem_we;
  logic [INDEX_WIDTH-1:0] mem_addr;
  logic [LRU_WIDTH-1:0]   mem_wdata;

  logic                   run, upd_acc, rd_acc;
  logic [STAGES:1]        vld_pipe;

  // Walk from the root: bit 0 -> left child (2i+1), 1 -> right (2i+2).
  // The directions taken, MSB first, spell the victim way.
  function automatic logic [WAY_WIDTH-1:0] plru_victim(input logic [LRU_WIDTH-1:0] tree);
    logic [WAY_WIDTH:0]   node;
    logic                 dir;
    logic [WAY_WIDTH-1:0] way;
    node = '0;
    way  = '0;
    for (int l = 0; l < WAY_WIDTH; l++) begin
      dir                  = tree[node[WAY_WIDTH-1:0]];
      way[WAY_WIDTH-1-l]   = dir;
      node                 = {node[WAY_WIDTH-1:0], 1'b1} + {{WAY_WIDTH{1'b0}}, dir};
    end
    return way;
  endfunction

  // Point every node on the accessed way's path away from it.
  function automatic logic [LRU_WIDTH-1:0] plru_update(input logic [LRU_WIDTH-1:0] tree,
                                                       input logic [WAY_WIDTH-1:0] way);
    logic [WAY_WIDTH:0]   node;
    logic                 dir;
    logic [LRU_WIDTH-1:0] t;
    node = '0;
    t    = tree;
    for (int l = 0; l < WAY_WIDTH; l++) begin
      dir                      = way[WAY_WIDTH-1-l];
      t[node[WAY_WIDTH-1:0]]   = ~dir;
      node                     = {node[WAY_WIDTH-1:0], 1'b1} + {{WAY_WIDTH{1'b0}}, dir};
    end
    return t;
  endfunction

  assign run         = (state_q == RUN);
  assign upd_ready_o = run & ~wb_q;
  assign rd_ready_o  = run & ~wb_q & ~upd_valid_i;
  assign upd_acc     = upd_valid_i & upd_ready_o;
  assign rd_acc      = rd_valid_i & rd_ready_o;

  // State register and sweep counter. The counter parks on the last index
  // once the sweep is done; only rst brings it back to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT && init_cnt_q != LAST_INDEX)
        init_cnt_q <= init_cnt_q + 1'b1;
    end
  end

  // Next state and SRAM port arbitration: sweep / write-back / update read /
  // lookup read, in that priority.
  always_comb begin
    state_d   = state_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == INIT) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = init_cnt_q;
      if (init_cnt_q == LAST_INDEX)
        state_d = RUN;
    end else if (wb_q) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wb_index_q;
      mem_wdata = plru_update(mem_rdata_q, wb_way_q);
    end else if (upd_valid_i) begin
      mem_en   = 1'b1;
      mem_addr = upd_index_i;
    end else if (rd_valid_i) begin
      mem_en   = 1'b1;
      mem_addr = rd_index_i;
    end
  end

  // Single-port synchronous SRAM; read data holds when not reading.
  always_ff @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata_q   <= mem[mem_addr];
    end
  end

  // Write-back capture, lookup valid pipe and output registers. Reset drops
  // any pending write-back by clearing wb_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe     <= '0;
      wb_q         <= 1'b0;
      wb_index_q   <= '0;
      wb_way_q     <= '0;
      rd_data_q    <= '0;
      victim_way_q <= '0;
      init_done_q  <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], rd_acc};
      wb_q     <= upd_acc;
      if (upd_acc) begin
        wb_index_q <= upd_index_i;
        wb_way_q   <= upd_way_i;
      end
      if (vld_pipe[1]) begin
        rd_data_q    <= mem_rdata_q;
        victim_way_q <= plru_victim(mem_rdata_q);
      end
      init_done_q <= run;
    end
  end

  assign rd_data_valid_q = vld_pipe[STAGES];

endmodule

// File: tb/tb_hnf_plru_sram_ctrl.sv
// Directed bench for hnf_plru_sram_ctrl at default parameters.
module tb_hnf_plru_sram_ctrl;
  localparam int IW = 10;
  localparam int LW = 15;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_valid = 1'b0;
  logic [IW-1:0] rd_index = '0;
  logic          rd_ready;
  logic          upd_valid = 1'b0;
  logic [IW-1:0] upd_index = '0;
  logic [WW-1:0] upd_way = '0;
  logic          upd_ready;
  logic          rd_data_valid;
  logic [LW-1:0] rd_data;
  logic [WW-1:0] victim_way;
  logic          init_done;

  int errors = 0;
  int checks = 0;

  hnf_plru_sram_ctrl #(.INDEX_WIDTH(IW), .WAYS(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .rd_valid_i      (rd_valid),
    .rd_index_i      (rd_index),
    .rd_ready_o      (rd_ready),
    .upd_valid_i     (upd_valid),
    .upd_index_i     (upd_index),
    .upd_way_i       (upd_way),
    .upd_ready_o     (upd_ready),
    .rd_data_valid_q (rd_data_valid),
    .rd_data_q       (rd_data),
    .victim_way_q    (victim_way),
    .init_done_q     (init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit            is_upd;
    logic [IW-1:0] idx;
    logic [WW-1:0] way;
    logic [LW-1:0] exp_data;
    logic [WW-1:0] exp_vict;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after rst drops (between edges). Holds a lookup request
  // through the sweep; neither ready may rise until 1024 edges have passed.
  task automatic run_init();
    int bad;
    bad = 0;
    rd_valid = 1'b1;
    rd_index = 10'd3;
    for (int k = 1; k <= 1023; k++) begin
      tick();
      if (rd_ready || upd_ready || init_done) bad++;
    end
    chk("init_ready_or_done_early", 32'(bad), 32'd0);
    rd_valid = 1'b0;
    tick();
    chk("init_done_at_1024", 32'(init_done), 32'd0);
    chk("rd_ready_at_1024", 32'(rd_ready), 32'd1);
    chk("upd_ready_at_1024", 32'(upd_ready), 32'd1);
    tick();
    chk("init_done_at_1025", 32'(init_done), 32'd1);
  endtask

  task automatic do_update(input logic [IW-1:0] idx, input logic [WW-1:0] way);
    upd_valid = 1'b1;
    upd_index = idx;
    upd_way   = way;
    #1;
    chk($sformatf("upd_ready[%0d]", idx), 32'(upd_ready), 32'd1);
    tick();
    upd_valid = 1'b0;
    #1;
    chk($sformatf("wb_upd_ready[%0d]", idx), 32'(upd_ready), 32'd0);
    chk($sformatf("wb_rd_ready[%0d]", idx), 32'(rd_ready), 32'd0);
    tick();
  endtask

  task automatic do_read(input logic [IW-1:0] idx, input logic [LW-1:0] ed, input logic [WW-1:0] ev);
    rd_valid = 1'b1;
    rd_index = idx;
    #1;
    chk($sformatf("rd_ready[%0d]", idx), 32'(rd_ready), 32'd1);
    tick();
    rd_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("rd_valid_t1[%0d]", idx), 32'(rd_data_valid), 32'd0);
    @(negedge clk);
    chk($sformatf("rd_valid_t2[%0d]", idx), 32'(rd_data_valid), 32'd1);
    chk($sformatf("rd_data[%0d]", idx), 32'(rd_data), 32'(ed));
    chk($sformatf("victim[%0d]", idx), 32'(victim_way), 32'(ev));
    tick();
    chk($sformatf("rd_valid_drop[%0d]", idx), 32'(rd_data_valid), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_ready"}, 32'(rd_ready), 32'd0);
    chk({tag, "_upd_ready"}, 32'(upd_ready), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_data_valid), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_victim"}, 32'(victim_way), 32'd0);
    chk({tag, "_init_done"}, 32'(init_done), 32'd0);
  endtask

  initial begin
    logic [LW-1:0] sdat [8];
    logic [WW-1:0] svic [8];

    // {is_upd, index, way, expected tree, expected victim}
    vecs[0]  = '{1'b0, 10'd1023, 4'd0,  15'h0000, 4'd0};
    vecs[1]  = '{1'b1, 10'd5,    4'd0,  15'h0000, 4'd0};
    vecs[2]  = '{1'b0, 10'd5,    4'd0,  15'h008B, 4'd8};
    vecs[3]  = '{1'b0, 10'd6,    4'd0,  15'h0000, 4'd0};
    vecs[4]  = '{1'b1, 10'd5,    4'd8,  15'h0000, 4'd0};
    vecs[5]  = '{1'b0, 10'd5,    4'd0,  15'h08AE, 4'd4};
    vecs[6]  = '{1'b1, 10'd7,    4'd15, 15'h0000, 4'd0};
    vecs[7]  = '{1'b1, 10'd7,    4'd3,  15'h0000, 4'd0};
    vecs[8]  = '{1'b0, 10'd7,    4'd0,  15'h0003, 4'd8};
    vecs[9]  = '{1'b1, 10'd100,  4'd6,  15'h0000, 4'd0};
    vecs[10] = '{1'b1, 10'd100,  4'd9,  15'h0000, 4'd0};
    vecs[11] = '{1'b0, 10'd100,  4'd0,  15'h0424, 4'd0};
    vecs[12] = '{1'b1, 10'd700,  4'd0,  15'h0000, 4'd0};
    vecs[13] = '{1'b0, 10'd700,  4'd0,  15'h008B, 4'd8};

    // Reset state, then the initial sweep.
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    run_init();

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_upd) do_update(vecs[i].idx, vecs[i].way);
      else                do_read(vecs[i].idx, vecs[i].exp_data, vecs[i].exp_vict);
    end

    // Lookup and update together: update wins, the lookup waits out the WB
    // and then sees 0x8AE updated for way 4 -> 0xABD, victim 12.
    rd_valid  = 1'b1;
    rd_index  = 10'd5;
    upd_valid = 1'b1;
    upd_index = 10'd5;
    upd_way   = 4'd4;
    #1;
    chk("coll_rd_ready_T", 32'(rd_ready), 32'd0);
    chk("coll_upd_ready_T", 32'(upd_ready), 32'd1);
    tick();
    upd_valid = 1'b0;
    #1;
    chk("coll_rd_ready_wb", 32'(rd_ready), 32'd0);
    chk("coll_upd_ready_wb", 32'(upd_ready), 32'd0);
    tick();
    chk("coll_rd_ready_T2", 32'(rd_ready), 32'd1);
    tick();
    rd_valid = 1'b0;
    @(negedge clk);
    chk("coll_valid_t1", 32'(rd_data_valid), 32'd0);
    @(negedge clk);
    chk("coll_valid_t2", 32'(rd_data_valid), 32'd1);
    chk("coll_data", 32'(rd_data), 32'h0ABD);
    chk("coll_victim", 32'(victim_way), 32'd12);
    tick();

    // Stream lookups to indices 0..7 back to back.
    sdat = '{15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0ABD, 15'h0, 15'h0003};
    svic = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd12, 4'd0, 4'd8};
    for (int c = 0; c < 12; c++) begin
      rd_valid = (c < 8);
      rd_index = 10'(c);
      #1;
      if (c < 8) chk($sformatf("stream_ready[%0d]", c), 32'(rd_ready), 32'd1);
      @(negedge clk);
      chk($sformatf("stream_valid[%0d]", c), 32'(rd_data_valid), 32'((c >= 2) && (c < 10)));
      if (c >= 2 && c < 10) begin
        chk($sformatf("stream_data[%0d]", c - 2), 32'(rd_data), 32'(sdat[c-2]));
        chk($sformatf("stream_victim[%0d]", c - 2), 32'(victim_way), 32'(svic[c-2]));
      end
      tick();
    end
    rd_valid = 1'b0;
    tick();
    chk("hold_data", 32'(rd_data), 32'h0003);
    chk("hold_victim", 32'(victim_way), 32'd8);

    // Reset in the middle of an update write-back.
    upd_valid = 1'b1;
    upd_index = 10'd7;
    upd_way   = 4'd0;
    #1;
    chk("wbrst_upd_ready", 32'(upd_ready), 32'd1);
    tick();
    upd_valid = 1'b0;
    #1;
    chk("wbrst_in_wb", 32'(upd_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("wbrst");

    // Interrupted sweep at cycle 300, then a full restart.
    @(negedge clk);
    rst = 1'b0;
    repeat (300) tick();
    chk("partial_init_done", 32'(init_done), 32'd0);
    rst = 1'b1;
    #1;
    chk_all_zero("rst300");
    @(negedge clk);
    rst = 1'b0;
    run_init();
    do_read(10'd700, 15'h0, 4'd0);
    do_read(10'd7,   15'h0, 4'd0);
    do_read(10'd5,   15'h0, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
